// File: rtl/pid_control_param.sv
// PID balance loop: moving-average angle error, P/I/D with clamped integral and anti-windup, sign-split saturated outputs.
// Latency: Result_Valid and new outputs appear 6 clocks after the accepting edge; Busy covers the 6 computation cycles.
// Backpressure: none; Sample_Valid while Busy is dropped. Optional macro PID_DFILT_EN adds a two-tap gyro filter.
module pid_control_param #(
    parameter int DATA_W   = 13,
    parameter int AVG_LOG2 = 2,
    parameter int GAIN_W   = 8,
    parameter int FRAC_W   = 2,
    parameter int INT_LIM  = 4096,
    parameter int OUT_W    = 16,
    parameter int OUT_MAX  = 7500
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Sample_Valid,
    input  logic signed [DATA_W-1:0] CurrentAngle,
    input  logic signed [DATA_W-1:0] CurrentGyro,
    input  logic signed [DATA_W-1:0] SetAngle,
    input  logic        [GAIN_W-1:0] Kp,
    input  logic        [GAIN_W-1:0] Ki,
    input  logic        [GAIN_W-1:0] Kd,
    output logic                     Busy,
    output logic                     Result_Valid,
    output logic        [OUT_W-1:0]  ResultOut_l,
    output logic        [OUT_W-1:0]  ResultOut_r
);

    localparam int ERR_W = DATA_W + 1;
    localparam int SUM_W = ERR_W + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = ERR_W + $clog2(INT_LIM + 1) + 1;
    localparam int MUL_W = ACC_W + GAIN_W + 1;
    localparam int U_W   = MUL_W + 2;

    localparam logic signed [ACC_W-1:0] LIM_P = ACC_W'(INT_LIM);
    localparam logic signed [ACC_W-1:0] LIM_N = -LIM_P;
    localparam logic signed [U_W-1:0]   OMAX  = U_W'(OUT_MAX);

    typedef enum logic [2:0] {S_IDLE, S_AVG, S_PT, S_IT, S_DT, S_SUM, S_OUT} state_t;
    state_t state, state_nxt;

    logic signed [ERR_W-1:0]  err_q, avg_q;
    logic signed [ERR_W-1:0]  avg_buf [DEPTH];
    logic        [PTR_W-1:0]  wr_ptr;
    logic signed [SUM_W-1:0]  sum_q, sum_nxt;
    logic signed [DATA_W-1:0] gyro_q, gyro_sel;
    logic signed [GAIN_W:0]   kp_s, ki_s, kd_s;
    logic signed [ACC_W-1:0]  integ_q, integ_sum, integ_clamped, integ_nxt;
    logic signed [MUL_W-1:0]  p_q, i_q, d_q;
    logic signed [U_W-1:0]    u_q, u_abs;
    logic                     sat_q, u_neg_q, hold_integ, u_sat;

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (Sample_Valid) state_nxt = S_AVG;
            S_AVG:   state_nxt = S_PT;
            S_PT:    state_nxt = S_IT;
            S_IT:    state_nxt = S_DT;
            S_DT:    state_nxt = S_SUM;
            S_SUM:   state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Busy    = (state != S_IDLE);
    assign sum_nxt = sum_q + SUM_W'(err_q) - SUM_W'(avg_buf[wr_ptr]);

    // Integral is frozen while the last output was clipped and the error still pushes the same way.
    assign hold_integ    = sat_q && (avg_q != '0) && (avg_q[ERR_W-1] == u_neg_q);
    assign integ_sum     = integ_q + ACC_W'(avg_q);
    assign integ_clamped = (integ_sum > LIM_P) ? LIM_P : (integ_sum < LIM_N) ? LIM_N : integ_sum;
    assign integ_nxt     = hold_integ ? integ_q : integ_clamped;

    assign u_abs = u_q[U_W-1] ? -u_q : u_q;
    assign u_sat = (u_abs > OMAX);

`ifdef PID_DFILT_EN
    localparam int GF_W = DATA_W + 3;
    logic signed [DATA_W-1:0] g_prev_q, gf_q;
    logic signed [GF_W-1:0]   gf_acc;
    assign gf_acc   = GF_W'(g_prev_q) + GF_W'(g_prev_q) + GF_W'(g_prev_q) + GF_W'(gyro_q);
    assign gyro_sel = gf_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            g_prev_q <= '0;
            gf_q     <= '0;
        end else if (state == S_AVG) begin
            gf_q     <= DATA_W'(gf_acc >>> 2);
            g_prev_q <= gyro_q;
        end
    end
`else
    assign gyro_sel = gyro_q;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q        <= '0;
            avg_q        <= '0;
            sum_q        <= '0;
            wr_ptr       <= '0;
            gyro_q       <= '0;
            kp_s         <= '0;
            ki_s         <= '0;
            kd_s         <= '0;
            integ_q      <= '0;
            p_q          <= '0;
            i_q          <= '0;
            d_q          <= '0;
            u_q          <= '0;
            sat_q        <= 1'b0;
            u_neg_q      <= 1'b0;
            Result_Valid <= 1'b0;
            ResultOut_l  <= '0;
            ResultOut_r  <= '0;
            for (int k = 0; k < DEPTH; k++) avg_buf[k] <= '0;
        end else begin
            Result_Valid <= 1'b0;
            unique case (state)
                S_IDLE: if (Sample_Valid) begin
                    err_q  <= ERR_W'(CurrentAngle) - ERR_W'(SetAngle);
                    gyro_q <= CurrentGyro;
                    kp_s   <= {1'b0, Kp};
                    ki_s   <= {1'b0, Ki};
                    kd_s   <= {1'b0, Kd};
                end
                S_AVG: begin
                    avg_buf[wr_ptr] <= err_q;
                    sum_q           <= sum_nxt;
                    avg_q           <= ERR_W'(sum_nxt >>> AVG_LOG2);
                    if (AVG_LOG2 == 0) wr_ptr <= '0;
                    else               wr_ptr <= wr_ptr + 1'b1;
                end
                S_PT: p_q <= kp_s * avg_q;
                S_IT: begin
                    integ_q <= integ_nxt;
                    i_q     <= ki_s * integ_nxt;
                end
                S_DT:  d_q <= kd_s * gyro_sel;
                S_SUM: u_q <= (U_W'(p_q) + U_W'(i_q) + U_W'(d_q)) >>> FRAC_W;
                S_OUT: begin
                    Result_Valid <= 1'b1;
                    sat_q        <= u_sat;
                    u_neg_q      <= u_q[U_W-1];
                    if (u_q > 0) begin
                        ResultOut_l <= u_sat ? OUT_W'(OUT_MAX) : u_abs[OUT_W-1:0];
                        ResultOut_r <= '0;
                    end else if (u_q < 0) begin
                        ResultOut_l <= '0;
                        ResultOut_r <= u_sat ? OUT_W'(OUT_MAX) : u_abs[OUT_W-1:0];
                    end else begin
                        ResultOut_l <= '0;
                        ResultOut_r <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_control_param.sv
// Bench for pid_control_param: directed vector table, hand-written corner sequences, randomized samples vs a reference model.
module tb_pid_control_param;

    localparam int DATA_W   = 13;
    localparam int AVG_LOG2 = 2;
    localparam int GAIN_W   = 8;
    localparam int FRAC_W   = 2;
    localparam int INT_LIM  = 4096;
    localparam int OUT_W    = 16;
    localparam int OUT_MAX  = 7500;
    localparam int DEPTH    = 1 << AVG_LOG2;

    logic                     Clk = 1'b0;
    logic                     Rst = 1'b1;
    logic                     Sample_Valid = 1'b0;
    logic signed [DATA_W-1:0] CurrentAngle = '0;
    logic signed [DATA_W-1:0] CurrentGyro = '0;
    logic signed [DATA_W-1:0] SetAngle = '0;
    logic        [GAIN_W-1:0] Kp = '0, Ki = '0, Kd = '0;
    logic                     Busy, Result_Valid;
    logic        [OUT_W-1:0]  ResultOut_l, ResultOut_r;

    pid_control_param #(
        .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W),
        .INT_LIM(INT_LIM), .OUT_W(OUT_W), .OUT_MAX(OUT_MAX)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Sample_Valid(Sample_Valid),
        .CurrentAngle(CurrentAngle), .CurrentGyro(CurrentGyro), .SetAngle(SetAngle),
        .Kp(Kp), .Ki(Ki), .Kd(Kd),
        .Busy(Busy), .Result_Valid(Result_Valid),
        .ResultOut_l(ResultOut_l), .ResultOut_r(ResultOut_r)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: sliding window of the last DEPTH errors, floor division, clamped integral.
    longint m_win[$];
    longint m_integ;
    bit     m_sat, m_neg;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_win.delete();
        for (int k = 0; k < DEPTH; k++) m_win.push_back(0);
        m_integ = 0;
        m_sat   = 1'b0;
        m_neg   = 1'b0;
    endtask

    task automatic model_step(input longint ang, input longint set, input longint gyro,
                              input longint kp, input longint ki, input longint kd,
                              output longint l, output longint r);
        longint err, s, avg, tent, u, mag, dummy;
        err = ang - set;
        m_win.push_back(err);
        dummy = m_win.pop_front();
        s = 0;
        foreach (m_win[k]) s += m_win[k];
        avg  = floor_div(s, DEPTH);
        tent = m_integ + avg;
        if (tent > INT_LIM)  tent = INT_LIM;
        if (tent < -INT_LIM) tent = -INT_LIM;
        if (!(m_sat && avg != 0 && ((avg < 0) == m_neg))) m_integ = tent;
        u   = floor_div(kp * avg + ki * m_integ + kd * gyro, 1 << FRAC_W);
        mag = (u < 0) ? -u : u;
        m_sat = (mag > OUT_MAX);
        m_neg = (u < 0);
        if (mag > OUT_MAX) mag = OUT_MAX;
        l = (u > 0) ? mag : 0;
        r = (u < 0) ? mag : 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        Sample_Valid = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input longint ang, input longint set, input longint gyro,
                         input longint kp, input longint ki, input longint kd);
        CurrentAngle = DATA_W'(ang);
        SetAngle     = DATA_W'(set);
        CurrentGyro  = DATA_W'(gyro);
        Kp = GAIN_W'(kp);
        Ki = GAIN_W'(ki);
        Kd = GAIN_W'(kd);
    endtask

    task automatic run_sample(input string name, input longint ang, input longint set, input longint gyro,
                              input longint kp, input longint ki, input longint kd,
                              input longint exp_l, input longint exp_r);
        int n;
        bit seen;
        @(negedge Clk);
        drive(ang, set, gyro, kp, ki, kd);
        Sample_Valid = 1'b1;
        @(negedge Clk);
        Sample_Valid = 1'b0;
        check({name, "_busy"}, Busy, 1);
        n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge Clk);
            n++;
            if (Result_Valid) seen = 1'b1;
        end
        check({name, "_lat"}, seen ? n : -1, 6);
        check({name, "_l"}, ResultOut_l, exp_l);
        check({name, "_r"}, ResultOut_r, exp_r);
        @(negedge Clk);
        check({name, "_rv_pulse"}, Result_Valid, 0);
    endtask

    typedef struct {
        bit rst;
        int ang, set, gyro, kp, ki, kd, l, r;
    } vec_t;

    vec_t vt[$];

    initial begin
        longint el, er;
        int rv_cnt, rv_at, ang, set, gyro, kp, ki, kd;

        // P only, negative/sign switch, saturation with frozen integral, integral clamp, D term
        for (int k = 0; k < 4; k++) vt.push_back('{k == 0, 100, 90, 0, 40, 0, 0, (k == 0) ? 20 : (k == 1) ? 50 : (k == 2) ? 70 : 100, 0});
        vt.push_back('{1'b1, 80, 90, 0, 40, 0, 0, 0, 30});
        vt.push_back('{1'b0, 80, 90, 0, 40, 0, 0, 0, 50});
        vt.push_back('{1'b0, 80, 90, 0, 40, 0, 0, 0, 80});
        vt.push_back('{1'b0, 80, 90, 0, 40, 0, 0, 0, 100});
        vt.push_back('{1'b0, 100, 90, 0, 40, 0, 0, 0, 50});
        vt.push_back('{1'b0, 100, 90, 0, 40, 0, 0, 0, 0});
        vt.push_back('{1'b0, 100, 90, 0, 40, 0, 0, 50, 0});
        vt.push_back('{1'b0, 100, 90, 0, 40, 0, 0, 100, 0});
        for (int k = 0; k < 4; k++) vt.push_back('{k == 0, 2000, 0, 0, 255, 0, 0, 7500, 0});
        vt.push_back('{1'b0, 2000, 0, 0, 0, 1, 0, 125, 0});
        vt.push_back('{1'b1, 1000, 0, 0, 0, 1, 0, 62, 0});
        vt.push_back('{1'b0, 1000, 0, 0, 0, 1, 0, 187, 0});
        vt.push_back('{1'b0, 1000, 0, 0, 0, 1, 0, 375, 0});
        vt.push_back('{1'b0, 1000, 0, 0, 0, 1, 0, 625, 0});
        vt.push_back('{1'b0, 1000, 0, 0, 0, 1, 0, 875, 0});
        for (int k = 0; k < 3; k++) vt.push_back('{1'b0, 1000, 0, 0, 0, 1, 0, 1024, 0});
        vt.push_back('{1'b1, 0, 0, -100, 0, 0, 10, 0, 250});

        do_reset();
        check("reset_busy", Busy, 0);
        check("reset_rv", Result_Valid, 0);
        check("reset_l", ResultOut_l, 0);
        check("reset_r", ResultOut_r, 0);

        foreach (vt[k]) begin
            if (vt[k].rst) do_reset();
            run_sample($sformatf("vec%0d", k), vt[k].ang, vt[k].set, vt[k].gyro,
                       vt[k].kp, vt[k].ki, vt[k].kd, vt[k].l, vt[k].r);
        end

        // Reset in the middle of a computation must abort it and clear the averaging window
        do_reset();
        run_sample("mr_pre0", 100, 90, 0, 40, 0, 0, 20, 0);
        run_sample("mr_pre1", 100, 90, 0, 40, 0, 0, 50, 0);
        @(negedge Clk);
        drive(100, 90, 0, 40, 0, 0);
        Sample_Valid = 1'b1;
        @(negedge Clk);
        Sample_Valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        rv_cnt = 0;
        repeat (2) begin
            @(negedge Clk);
            if (Result_Valid) rv_cnt++;
        end
        Rst = 1'b0;
        model_reset();
        repeat (8) begin
            @(negedge Clk);
            if (Result_Valid) rv_cnt++;
        end
        check("mr_no_rv", rv_cnt, 0);
        check("mr_busy", Busy, 0);
        check("mr_l", ResultOut_l, 0);
        check("mr_r", ResultOut_r, 0);
        run_sample("mr_post", 100, 90, 0, 40, 0, 0, 20, 0);

        // Strobes at accept+1 and accept+3 carry different data and must be dropped
        do_reset();
        @(negedge Clk);
        drive(100, 90, 0, 40, 0, 0);
        Sample_Valid = 1'b1;
        @(negedge Clk);
        drive(2000, 0, 0, 40, 0, 0);
        rv_cnt = 0;
        rv_at  = -1;
        for (int n = 1; n <= 14; n++) begin
            Sample_Valid = (n == 1 || n == 3);
            @(negedge Clk);
            if (Result_Valid) begin
                rv_cnt++;
                if (rv_at < 0) rv_at = n;
                check("drop_l", ResultOut_l, 20);
                check("drop_r", ResultOut_r, 0);
            end
        end
        Sample_Valid = 1'b0;
        check("drop_rv_count", rv_cnt, 1);
        check("drop_rv_at", rv_at, 6);
        run_sample("drop_next", 100, 90, 0, 40, 0, 0, 50, 0);

        // Randomized samples against the model
        do_reset();
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            ang  = int'($urandom_range(0, 4000)) - 2000;
            set  = int'($urandom_range(0, 4000)) - 2000;
            gyro = int'($urandom_range(0, 8190)) - 4095;
            kp   = int'($urandom_range(0, 255));
            ki   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            kd   = int'($urandom_range(0, 255));
            model_step(ang, set, gyro, kp, ki, kd, el, er);
            run_sample($sformatf("rnd%0d", k), ang, set, gyro, kp, ki, kd, el, er);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
